ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 30 +++
 rtl/ram_arbiter_rr_picker.sv | 33 +++
 rtl/ram_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ============================================================================
//  Module      : ram_arb_pkg
//  Description : Shared types for the RAM arbiter (requester id, read tag).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

   localparam int N_REQ_DEFAULT = 4;
   localparam int N_REQ_MAX     = 8;
   // Id width is sized for the largest supported requester count so one
   // typedef serves every legal N_REQ.
   localparam int ID_W          = $clog2(N_REQ_MAX);

   typedef logic [ID_W-1:0] req_id_t;

   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_tag_t;

   // Pointer value that gives requester 0 the highest priority.
   function automatic req_id_t ptr_reset(input int n);
      return req_id_t'(n - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_rr_picker.sv
// ============================================================================
//  Module      : rr_picker
//  Description : Round-robin picker; search starts one above ptr, one-hot out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
   import ram_arb_pkg::*;
#(
   parameter int N = N_REQ_DEFAULT
) (
   input  logic [N-1:0] req,
   input  req_id_t      ptr,
   output logic [N-1:0] gnt
);

   req_id_t        shift;
   logic [N-1:0]   rot;
   logic [N-1:0]   rot_gnt;

   // Rotate so the first candidate sits at bit 0, take the lowest set bit,
   // then rotate the grant back into place.
   always_comb begin
      shift   = (ptr == req_id_t'(N - 1)) ? '0 : ptr + req_id_t'(1);
      rot     = N'({req, req} >> shift);
      rot_gnt = rot & (~rot + N'(1));
      gnt     = N'(({rot_gnt, rot_gnt} << shift) >> N);
   end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
//  Module      : ram_arbiter
//  Description : N-requester arbiter onto a 1W/1R synchronous RAM with
//                independent round-robin write and read arbitration.
//                Optional write lock enabled by macro RAM_ARB_LOCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int N_REQ   = N_REQ_DEFAULT,
   parameter int D_WIDTH = 32,
   parameter int A_WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ-1:0]           req_we,
   input  logic [N_REQ*A_WIDTH-1:0]   req_addr,
   input  logic [N_REQ*D_WIDTH-1:0]   req_wdata,
`ifdef RAM_ARB_LOCK_EN
   input  logic [N_REQ-1:0]           req_lock,
`endif
   output logic [N_REQ-1:0]           req_ready,
   output logic [N_REQ-1:0]           rsp_valid,
   output logic [D_WIDTH-1:0]         rsp_rdata,
   output logic                       write_en,
   output logic [A_WIDTH-1:0]         write_addr,
   output logic [D_WIDTH-1:0]         write_data,
   output logic                       read_en,
   output logic [A_WIDTH-1:0]         read_addr,
   input  logic [D_WIDTH-1:0]         read_data
);

   logic [N_REQ-1:0]   wr_req, rd_req, wr_pick, rd_cand, wr_gnt, rd_gnt;
   req_id_t            wr_id, rd_id;
   logic [A_WIDTH-1:0] wr_addr, rd_addr;
   logic [D_WIDTH-1:0] wr_data;
   logic               wr_any, rd_any;

   req_id_t            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic               write_en_q, write_en_d, read_en_q, read_en_d;
   logic [A_WIDTH-1:0] write_addr_q, write_addr_d, read_addr_q, read_addr_d;
   logic [D_WIDTH-1:0] write_data_q, write_data_d, rdata_hold_q, rdata_hold_d;
   rd_tag_t            tag1_q, tag1_d, tag2_q, tag2_d;

   assign wr_req = req_valid & req_we;
   assign rd_req = req_valid & ~req_we;

   rr_picker #(.N(N_REQ)) u_wr_pick (
      .req (wr_req),
      .ptr (wr_ptr_q),
      .gnt (wr_pick)
   );

   rr_picker #(.N(N_REQ)) u_rd_pick (
      .req (rd_req),
      .ptr (rd_ptr_q),
      .gnt (rd_cand)
   );

`ifdef RAM_ARB_LOCK_EN
   logic [N_REQ-1:0] lock_q, lock_d;
   logic             lock_hold;

   // lock_q holds the one-hot owner; it persists while the owner keeps writing.
   always_comb begin
      lock_hold = |(wr_req & lock_q);
      wr_gnt    = lock_hold ? lock_q : wr_pick;
      lock_d    = lock_hold ? lock_q : '0;
      if (|(wr_gnt & req_lock)) lock_d = wr_gnt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lock_q <= '0;
      else      lock_q <= lock_d;
   end
`else
   assign wr_gnt = wr_pick;
`endif

   always_comb begin
      wr_id   = '0;
      rd_id   = '0;
      wr_addr = '0;
      wr_data = '0;
      rd_addr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (wr_gnt[i]) begin
            wr_id   = req_id_t'(i);
            wr_addr = req_addr[i*A_WIDTH +: A_WIDTH];
            wr_data = req_wdata[i*D_WIDTH +: D_WIDTH];
         end
         if (rd_cand[i]) begin
            rd_id   = req_id_t'(i);
            rd_addr = req_addr[i*A_WIDTH +: A_WIDTH];
         end
      end
      wr_any    = |wr_gnt;
      // A read hitting the address being written this cycle waits one cycle
      // so it observes the new data.
      rd_gnt    = (wr_any && (rd_addr == wr_addr)) ? '0 : rd_cand;
      rd_any    = |rd_gnt;
      req_ready = wr_gnt | rd_gnt;
   end

   always_comb begin
      wr_ptr_d     = wr_any ? wr_id : wr_ptr_q;
      rd_ptr_d     = rd_any ? rd_id : rd_ptr_q;
      write_en_d   = wr_any;
      write_addr_d = wr_addr;
      write_data_d = wr_data;
      read_en_d    = rd_any;
      read_addr_d  = rd_addr;
      tag1_d.valid = rd_any;
      tag1_d.id    = rd_id;
      tag2_d       = tag1_q;
      rdata_hold_d = tag2_q.valid ? read_data : rdata_hold_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q     <= ptr_reset(N_REQ);
         rd_ptr_q     <= ptr_reset(N_REQ);
         write_en_q   <= 1'b0;
         write_addr_q <= '0;
         write_data_q <= '0;
         read_en_q    <= 1'b0;
         read_addr_q  <= '0;
         tag1_q       <= '0;
         tag2_q       <= '0;
         rdata_hold_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         write_en_q   <= write_en_d;
         write_addr_q <= write_addr_d;
         write_data_q <= write_data_d;
         read_en_q    <= read_en_d;
         read_addr_q  <= read_addr_d;
         tag1_q       <= tag1_d;
         tag2_q       <= tag2_d;
         rdata_hold_q <= rdata_hold_d;
      end
   end

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         rsp_valid[i] = tag2_q.valid && (tag2_q.id == req_id_t'(i));
      end
   end

   assign rsp_rdata  = tag2_q.valid ? read_data : rdata_hold_q;
   assign write_en   = write_en_q;
   assign write_addr = write_addr_q;
   assign write_data = write_data_q;
   assign read_en    = read_en_q;
   assign read_addr  = read_addr_q;

endmodule

`default_nettype wire
